// File: rtl/apb_i2c_regif_if.sv
// APB slave bus bundle for apb_i2c_regif; clock and reset stay outside the interface.
interface apb_i2c_regif_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [15:0]       PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_i2c_regif.sv
// APB register block for an I2C core: config/timeout regs, TX/RX FIFOs and interrupts.
// The RX FIFO is built only when APB_I2C_RX_FIFO_EN is defined.
module apb_i2c_regif #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned CFG_W    = 14,
    parameter int unsigned TX_DEPTH = 8,
    parameter int unsigned RX_DEPTH = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_i2c_regif_if.slave    apb,
    output logic [CFG_W-1:0]  CFG_REG,
    output logic [CFG_W-1:0]  TIMEOUT_REG,
    output logic [DATA_W-1:0] TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_POP,
    input  logic [DATA_W-1:0] RX_DATA,
    input  logic              RX_PUSH,
    input  logic              CORE_ERROR,
    output logic              INT_TX,
    output logic              INT_RX
);
    localparam int unsigned TxPtrW = $clog2(TX_DEPTH);
    localparam int unsigned TxCntW = TxPtrW + 1;
    localparam int unsigned RxCntW = $clog2(RX_DEPTH) + 1;

    localparam logic [4:0] AddrTx    = 5'h00;
    localparam logic [4:0] AddrCfg   = 5'h04;
    localparam logic [4:0] AddrTo    = 5'h08;
    localparam logic [4:0] AddrRx    = 5'h0C;
    localparam logic [4:0] AddrStat  = 5'h10;
    localparam logic [4:0] AddrIrqEn = 5'h14;
    localparam logic [4:0] AddrIrqSt = 5'h18;

    logic              access;
    logic [4:0]        addr;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] status;
    logic              slv_err;
    logic              tx_wr, rx_rd, cfg_we, to_we, en_we, stat_w1c;
    logic              tx_ovf, rx_udf, rx_ovf;

    logic [CFG_W-1:0]  cfg_q, to_q;
    logic [4:0]        irq_en_q, irq_stat_q, irq_stat_d, irq_set;
    logic              int_tx_q, int_rx_q, core_err_q;

    logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
    logic [TxPtrW-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
    logic [TxCntW-1:0] tx_cnt_q, tx_cnt_d;
    logic              tx_empty, tx_full, tx_pop;

    logic [RxCntW-1:0] rx_cnt, rx_cnt_d;
    logic              rx_empty, rx_full;
`ifdef APB_I2C_RX_FIFO_EN
    logic [DATA_W-1:0] rx_head;
`endif

    logic unused_addr;
    assign unused_addr = ^apb.PADDR[15:5];

    assign access   = apb.PSELx & apb.PENABLE;
    assign addr     = apb.PADDR[4:0];
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == TxCntW'(TX_DEPTH));
    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == RxCntW'(RX_DEPTH));

    always_comb begin
        status        = '0;
        status[7:0]   = 8'(tx_cnt_q);
        status[15:8]  = 8'(rx_cnt);
        status[16]    = tx_empty;
        status[17]    = tx_full;
        status[18]    = rx_empty;
        status[19]    = rx_full;
        status[20]    = CORE_ERROR;
    end

    // Register decode; every error path returns zero data and suppresses the side effect.
    always_comb begin
        rdata    = '0;
        slv_err  = 1'b0;
        tx_wr    = 1'b0;
        rx_rd    = 1'b0;
        cfg_we   = 1'b0;
        to_we    = 1'b0;
        en_we    = 1'b0;
        stat_w1c = 1'b0;
        tx_ovf   = 1'b0;
        rx_udf   = 1'b0;
        if (access) begin
            case (addr)
                AddrTx: begin
                    if (!apb.PWRITE) begin
                        slv_err = 1'b1;
                    end else if (tx_full) begin
                        slv_err = 1'b1;
                        tx_ovf  = 1'b1;
                    end else begin
                        tx_wr = 1'b1;
                    end
                end
                AddrCfg: begin
                    if (apb.PWRITE) cfg_we = 1'b1;
                    else            rdata  = DATA_W'(cfg_q);
                end
                AddrTo: begin
                    if (apb.PWRITE) to_we = 1'b1;
                    else            rdata = DATA_W'(to_q);
                end
                AddrRx: begin
                    slv_err = 1'b1;
`ifdef APB_I2C_RX_FIFO_EN
                    if (!apb.PWRITE) begin
                        if (rx_empty) begin
                            rx_udf = 1'b1;
                        end else begin
                            slv_err = 1'b0;
                            rdata   = rx_head;
                            rx_rd   = 1'b1;
                        end
                    end
`endif
                end
                AddrStat: begin
                    if (apb.PWRITE) slv_err = 1'b1;
                    else            rdata   = status;
                end
                AddrIrqEn: begin
                    if (apb.PWRITE) en_we = 1'b1;
                    else            rdata = DATA_W'(irq_en_q);
                end
                AddrIrqSt: begin
                    if (apb.PWRITE) stat_w1c = 1'b1;
                    else            rdata    = DATA_W'(irq_stat_q);
                end
                default: slv_err = 1'b1;
            endcase
        end
    end

    // Bus outputs are forced low while reset is asserted, even mid-access.
    assign apb.PREADY  = PRESETn & access;
    assign apb.PSLVERR = PRESETn & slv_err;
    assign apb.PRDATA  = PRESETn ? rdata : '0;

    // TX FIFO
    assign tx_pop   = TX_POP & ~tx_empty;
    assign tx_cnt_d = tx_cnt_q + TxCntW'(tx_wr) - TxCntW'(tx_pop);
    assign TX_VALID = ~tx_empty;
    assign TX_DATA  = tx_empty ? '0 : tx_mem_q[tx_rd_ptr_q];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
        end else begin
            if (tx_wr)  tx_wr_ptr_q <= tx_wr_ptr_q + TxPtrW'(1);
            if (tx_pop) tx_rd_ptr_q <= tx_rd_ptr_q + TxPtrW'(1);
            tx_cnt_q <= tx_cnt_d;
        end
    end

    always_ff @(posedge PCLK) begin
        if (tx_wr) tx_mem_q[tx_wr_ptr_q] <= apb.PWDATA;
    end

`ifdef APB_I2C_RX_FIFO_EN
    localparam int unsigned RxPtrW = $clog2(RX_DEPTH);

    logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
    logic [RxPtrW-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
    logic [RxCntW-1:0] rx_cnt_q;
    logic              rx_push;

    // Fullness is judged before any same-cycle pop, so a push into a full FIFO is lost.
    assign rx_push  = RX_PUSH & ~rx_full;
    assign rx_ovf   = RX_PUSH & rx_full;
    assign rx_cnt   = rx_cnt_q;
    assign rx_cnt_d = rx_cnt_q + RxCntW'(rx_push) - RxCntW'(rx_rd);
    assign rx_head  = rx_mem_q[rx_rd_ptr_q];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
        end else begin
            if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + RxPtrW'(1);
            if (rx_rd)   rx_rd_ptr_q <= rx_rd_ptr_q + RxPtrW'(1);
            rx_cnt_q <= rx_cnt_d;
        end
    end

    always_ff @(posedge PCLK) begin
        if (rx_push) rx_mem_q[rx_wr_ptr_q] <= RX_DATA;
    end
`else
    logic unused_rx;
    assign unused_rx = ^{RX_DATA, RX_PUSH, rx_rd};
    assign rx_ovf    = 1'b0;
    assign rx_cnt    = '0;
    assign rx_cnt_d  = '0;
`endif

    // Interrupt status: set events take priority over a same-cycle write-1-to-clear.
    always_comb begin
        irq_set    = '0;
        irq_set[0] = (tx_cnt_q != '0) && (tx_cnt_d == '0);
        irq_set[1] = (rx_cnt == '0) && (rx_cnt_d != '0);
        irq_set[2] = tx_ovf;
        irq_set[3] = rx_udf;
        irq_set[4] = (CORE_ERROR & ~core_err_q) | rx_ovf;
        irq_stat_d = (irq_stat_q & ~(stat_w1c ? apb.PWDATA[4:0] : 5'b0)) | irq_set;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cfg_q      <= '0;
            to_q       <= '0;
            irq_en_q   <= '0;
            irq_stat_q <= '0;
            int_tx_q   <= 1'b0;
            int_rx_q   <= 1'b0;
            core_err_q <= 1'b0;
        end else begin
            if (cfg_we) cfg_q    <= apb.PWDATA[CFG_W-1:0];
            if (to_we)  to_q     <= apb.PWDATA[CFG_W-1:0];
            if (en_we)  irq_en_q <= apb.PWDATA[4:0];
            irq_stat_q <= irq_stat_d;
            int_tx_q   <= |(irq_stat_q & irq_en_q & 5'b00101);
            int_rx_q   <= |(irq_stat_q & irq_en_q & 5'b11010);
            core_err_q <= CORE_ERROR;
        end
    end

    assign CFG_REG     = cfg_q;
    assign TIMEOUT_REG = to_q;
    assign INT_TX      = int_tx_q;
    assign INT_RX      = int_rx_q;
endmodule

// File: tb/tb_apb_i2c_regif.sv
// Randomized bench for apb_i2c_regif against a queue-based register/FIFO model.
module tb_apb_i2c_regif;
    localparam int TxDepth = 8;
    localparam int RxDepth = 8;
`ifdef APB_I2C_RX_FIFO_EN
    localparam bit RxEn = 1'b1;
`else
    localparam bit RxEn = 1'b0;
`endif

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [13:0] CFG_REG, TIMEOUT_REG;
    logic [31:0] TX_DATA, RX_DATA;
    logic        TX_VALID, TX_POP, RX_PUSH, CORE_ERROR, INT_TX, INT_RX;

    apb_i2c_regif_if #(.DATA_W(32)) apb ();

    apb_i2c_regif #(
        .DATA_W(32), .CFG_W(14), .TX_DEPTH(TxDepth), .RX_DEPTH(RxDepth)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .apb(apb),
        .CFG_REG(CFG_REG), .TIMEOUT_REG(TIMEOUT_REG),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_POP(TX_POP),
        .RX_DATA(RX_DATA), .RX_PUSH(RX_PUSH), .CORE_ERROR(CORE_ERROR),
        .INT_TX(INT_TX), .INT_RX(INT_RX)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] txq [$];
    logic [31:0] rxq [$];
    logic [31:0] m_cfg, m_to, m_en, m_stat;
    bit          m_int_tx, m_int_rx, m_cerr;
    bit          cerr_lvl;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        txq.delete();
        rxq.delete();
        m_cfg = 0; m_to = 0; m_en = 0; m_stat = 0;
        m_int_tx = 0; m_int_rx = 0; m_cerr = 0;
    endtask

    // One clock of the register block seen from the outside.
    task automatic model_step(input bit acc, input bit wr, input logic [4:0] a,
                              input logic [31:0] wd, input bit pop, input bit push,
                              input logic [31:0] rxd, input bit cerr,
                              output logic [31:0] e_rd, output bit e_err);
        int          txn, rxn;
        logic [31:0] set, w1c, s;
        bit          tx_push, rx_pop, nx_int_tx, nx_int_rx;
        txn = txq.size();
        rxn = rxq.size();
        set = 0; w1c = 0; tx_push = 0; rx_pop = 0; e_rd = 0; e_err = 0;
        nx_int_tx = |(m_stat & m_en & 32'h05);
        nx_int_rx = |(m_stat & m_en & 32'h1A);
        if (acc) begin
            case (a)
                5'h00: if (!wr) e_err = 1;
                       else if (txn == TxDepth) begin e_err = 1; set |= 32'h4; end
                       else tx_push = 1;
                5'h04: if (wr) m_cfg = wd & 32'h3FFF; else e_rd = m_cfg;
                5'h08: if (wr) m_to = wd & 32'h3FFF; else e_rd = m_to;
                5'h0C: if (wr || !RxEn) e_err = 1;
                       else if (rxn == 0) begin e_err = 1; set |= 32'h8; end
                       else begin e_rd = rxq[0]; rx_pop = 1; end
                5'h10: if (wr) e_err = 1;
                       else begin
                           s = 0;
                           s[7:0] = 8'(txn);
                           s[15:8] = 8'(rxn);
                           s[16] = (txn == 0);
                           s[17] = (txn == TxDepth);
                           s[18] = (rxn == 0);
                           s[19] = (rxn == RxDepth);
                           s[20] = cerr;
                           e_rd = s;
                       end
                5'h14: if (wr) m_en = wd & 32'h1F; else e_rd = m_en;
                5'h18: if (wr) w1c = wd & 32'h1F; else e_rd = m_stat;
                default: e_err = 1;
            endcase
        end
        if (pop && txn > 0) void'(txq.pop_front());
        if (tx_push) txq.push_back(wd);
        if (rx_pop) void'(rxq.pop_front());
        if (RxEn && push) begin
            if (rxn == RxDepth) set |= 32'h10;
            else rxq.push_back(rxd);
        end
        if (txn > 0 && txq.size() == 0) set |= 32'h1;
        if (rxn == 0 && rxq.size() > 0) set |= 32'h2;
        if (cerr && !m_cerr) set |= 32'h10;
        m_cerr   = cerr;
        m_stat   = (m_stat & ~w1c) | set;
        m_int_tx = nx_int_tx;
        m_int_rx = nx_int_rx;
    endtask

    // Called 1 time unit after a rising edge; returns 1 after the next rising edge.
    task automatic drive_cycle(input bit sel, input bit en, input bit wr, input logic [15:0] addr,
                               input logic [31:0] wd, input bit pop, input bit push,
                               input logic [31:0] rxd, input bit cerr,
                               output logic [31:0] got_rd, output bit got_err);
        logic [31:0] e_rd;
        bit          e_err;
        apb.PSELx = sel; apb.PENABLE = en; apb.PWRITE = wr; apb.PADDR = addr; apb.PWDATA = wd;
        TX_POP = pop; RX_PUSH = push; RX_DATA = rxd; CORE_ERROR = cerr;
        #3;
        model_step(sel && en, wr, addr[4:0], wd, pop, push, rxd, cerr, e_rd, e_err);
        got_rd  = apb.PRDATA;
        got_err = apb.PSLVERR;
        check_eq("pready", 32'(apb.PREADY), 32'(sel && en));
        if (sel && en) begin
            check_eq("prdata", apb.PRDATA, e_rd);
            check_eq("pslverr", 32'(apb.PSLVERR), 32'(e_err));
        end
        @(posedge PCLK);
        #1;
        check_eq("cfg_reg", 32'(CFG_REG), m_cfg);
        check_eq("timeout_reg", 32'(TIMEOUT_REG), m_to);
        check_eq("tx_valid", 32'(TX_VALID), 32'(txq.size() > 0));
        if (txq.size() > 0) check_eq("tx_data", TX_DATA, txq[0]);
        check_eq("int_tx", 32'(INT_TX), 32'(m_int_tx));
        check_eq("int_rx", 32'(INT_RX), 32'(m_int_rx));
    endtask

    task automatic apb_xfer(input bit wr, input logic [15:0] a, input logic [31:0] d,
                            input bit pop, output logic [31:0] rd, output bit err);
        logic [31:0] r0;
        bit          e0;
        drive_cycle(1, 0, wr, a, d, 0, 0, 0, cerr_lvl, r0, e0);
        drive_cycle(1, 1, wr, a, d, pop, 0, 0, cerr_lvl, rd, err);
    endtask

    task automatic apb_wr(input logic [15:0] a, input logic [31:0] d, output bit err);
        logic [31:0] rd;
        apb_xfer(1, a, d, 0, rd, err);
    endtask

    task automatic apb_rd(input logic [15:0] a, output logic [31:0] rd, output bit err);
        apb_xfer(0, a, 0, 0, rd, err);
    endtask

    task automatic idle(input bit pop, input bit push, input logic [31:0] rxd);
        logic [31:0] rd;
        bit          err;
        drive_cycle(0, 0, 0, 0, 0, pop, push, rxd, cerr_lvl, rd, err);
    endtask

    task automatic rand_core(input bit slow, output bit pop, output bit push, output logic [31:0] d);
        pop  = slow ? ($urandom_range(0, 31) == 0) : ($urandom_range(0, 2) == 0);
        push = slow ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 31) == 0);
        d    = $urandom();
    endtask

    task automatic random_phase(input int n);
        logic [4:0]  a5;
        logic [15:0] pa;
        logic [31:0] wd, rxd, rd;
        bit          w, pop, push, err, slow;
        int          k;
        for (int i = 0; i < n; i++) begin
            k = $urandom_range(0, 9);
            case (k)
                0, 1: a5 = 5'h00;
                2: a5 = 5'h04;
                3: a5 = 5'h08;
                4, 5: a5 = 5'h0C;
                6: a5 = 5'h10;
                7: a5 = 5'h14;
                8: a5 = 5'h18;
                default: a5 = 5'($urandom_range(0, 31));
            endcase
            pa = {11'($urandom_range(0, 2047)), a5};
            if (a5 == 5'h00) w = ($urandom_range(0, 3) != 0);
            else if (a5 == 5'h0C) w = ($urandom_range(0, 3) == 0);
            else w = 1'($urandom_range(0, 1));
            wd = $urandom();
            if ($urandom_range(0, 15) == 0) cerr_lvl = ~cerr_lvl;
            slow = ((i / 250) % 2) == 0;
            rand_core(slow, pop, push, rxd);
            drive_cycle(1, 0, w, pa, wd, pop, push, rxd, cerr_lvl, rd, err);
            rand_core(slow, pop, push, rxd);
            drive_cycle(1, 1, w, pa, wd, pop, push, rxd, cerr_lvl, rd, err);
            if ($urandom_range(0, 7) == 0) begin
                rand_core(slow, pop, push, rxd);
                drive_cycle(0, 0, 0, 0, 0, pop, push, rxd, cerr_lvl, rd, err);
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        bit          err;

        // Reset state, with an access phase presented while reset is held.
        model_reset();
        cerr_lvl = 0;
        PRESETn = 0;
        apb.PSELx = 1; apb.PENABLE = 1; apb.PWRITE = 0; apb.PADDR = 16'h0010; apb.PWDATA = 0;
        TX_POP = 0; RX_PUSH = 0; RX_DATA = 0; CORE_ERROR = 0;
        #2;
        check_eq("rst_pready", 32'(apb.PREADY), 0);
        check_eq("rst_prdata", apb.PRDATA, 0);
        check_eq("rst_cfg", 32'(CFG_REG), 0);
        check_eq("rst_tx_valid", 32'(TX_VALID), 0);
        check_eq("rst_ints", 32'({INT_TX, INT_RX}), 0);
        apb.PSELx = 0; apb.PENABLE = 0;
        repeat (2) @(posedge PCLK);
        #1;
        PRESETn = 1;

        // CONFIG / TIMEOUT width and readback.
        apb_wr(16'h0004, 32'hFFFF_FFFF, err);
        check_eq("cfg_full", 32'(CFG_REG), 32'h3FFF);
        apb_rd(16'h0004, rd, err);
        check_eq("cfg_rdbk", rd, 32'h0000_3FFF);
        check_eq("cfg_rd_err", 32'(err), 0);
        apb_wr(16'h0008, 32'h0001_2345, err);
        check_eq("to_trunc", 32'(TIMEOUT_REG), 32'h2345);

        // Fill TX, overflow, interrupt and W1C.
        for (int i = 0; i < TxDepth; i++) apb_wr(16'h0000, 32'h100 + i, err);
        apb_wr(16'h0000, 32'hBAD, err);
        check_eq("tx_ovf_err", 32'(err), 1);
        apb_rd(16'h0010, rd, err);
        check_eq("tx_full_bit", 32'(rd[17]), 1);
        apb_rd(16'h0018, rd, err);
        check_eq("tx_ovf_irq", 32'(rd[2]), 1);
        apb_wr(16'h0014, 32'h4, err);
        idle(0, 0, 0);
        check_eq("int_tx_on", 32'(INT_TX), 1);
        apb_wr(16'h0018, 32'h4, err);
        idle(0, 0, 0);
        check_eq("int_tx_off", 32'(INT_TX), 0);

        // Write to a full FIFO coinciding with a pop is still rejected.
        apb_xfer(1, 16'h0000, 32'hCAFE, 1, rd, err);
        check_eq("full_pop_err", 32'(err), 1);
        apb_rd(16'h0010, rd, err);
        check_eq("full_pop_cnt", 32'(rd[7:0]), 7);

        // Drain TX; the count reaching zero raises IRQ_STAT[0].
        for (int i = 0; i < 7; i++) idle(1, 0, 0);
        apb_rd(16'h0018, rd, err);
        check_eq("tx_empty_irq", 32'(rd[0]), 1);

`ifdef APB_I2C_RX_FIFO_EN
        idle(0, 1, 32'hA5);
        apb_rd(16'h0018, rd, err);
        check_eq("rx_irq", 32'(rd[1]), 1);
        apb_rd(16'h000C, rd, err);
        check_eq("rx_head", rd, 32'hA5);
        check_eq("rx_rd_err", 32'(err), 0);
        apb_rd(16'h0010, rd, err);
        check_eq("rx_cnt0", 32'(rd[15:8]), 0);
        apb_rd(16'h000C, rd, err);
        check_eq("rx_udf_data", rd, 0);
        check_eq("rx_udf_err", 32'(err), 1);
        apb_rd(16'h0018, rd, err);
        check_eq("rx_udf_irq", 32'(rd[3]), 1);
`else
        apb_wr(16'h0014, 32'h1F, err);
        idle(0, 1, 32'hA5);
        apb_rd(16'h0010, rd, err);
        check_eq("norx_empty", 32'(rd[18]), 1);
        check_eq("norx_cnt", 32'(rd[15:8]), 0);
        apb_rd(16'h000C, rd, err);
        check_eq("norx_err", 32'(err), 1);
        check_eq("norx_data", rd, 0);
        idle(0, 1, 32'h5A);
        idle(0, 0, 0);
        check_eq("norx_int_rx", 32'(INT_RX), 0);
`endif

        // Illegal accesses leave state alone.
        apb_rd(16'h001C, rd, err);
        check_eq("unmap_err", 32'(err), 1);
        check_eq("unmap_data", rd, 0);
        apb_wr(16'h0010, 32'hFFFF_FFFF, err);
        check_eq("ro_wr_err", 32'(err), 1);
        apb_rd(16'h0000, rd, err);
        check_eq("wo_rd_err", 32'(err), 1);
        check_eq("cfg_kept", 32'(CFG_REG), 32'h3FFF);

        // CORE_ERROR rising edge, not its level, raises IRQ_STAT[4].
        apb_wr(16'h0014, 32'h1F, err);
        apb_wr(16'h0018, 32'h1F, err);
        idle(0, 0, 0);
        idle(0, 0, 0);
        check_eq("int_rx_clr", 32'(INT_RX), 0);
        cerr_lvl = 1;
        idle(0, 0, 0);
        idle(0, 0, 0);
        check_eq("cerr_int_rx", 32'(INT_RX), 1);
        apb_wr(16'h0018, 32'h10, err);
        idle(0, 0, 0);
        idle(0, 0, 0);
        check_eq("cerr_level", 32'(INT_RX), 0);
        cerr_lvl = 0;

        random_phase(1500);

        // Reset dropped in the middle of an access phase.
        cerr_lvl = 0;
        apb_wr(16'h0004, 32'h155, err);
        apb_wr(16'h0008, 32'h77, err);
        apb_wr(16'h0014, 32'h1F, err);
        apb_wr(16'h0000, 32'hDEAD, err);
        idle(0, 0, 0);
        apb.PSELx = 1; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = 16'h0004;
        TX_POP = 0; RX_PUSH = 0; CORE_ERROR = 0;
        @(posedge PCLK);
        #1;
        apb.PENABLE = 1;
        #2;
        check_eq("mid_pready", 32'(apb.PREADY), 1);
        PRESETn = 0;
        #1;
        check_eq("mid_pready_rst", 32'(apb.PREADY), 0);
        check_eq("mid_prdata_rst", apb.PRDATA, 0);
        check_eq("mid_pslverr_rst", 32'(apb.PSLVERR), 0);
        check_eq("mid_cfg_rst", 32'(CFG_REG), 0);
        check_eq("mid_to_rst", 32'(TIMEOUT_REG), 0);
        check_eq("mid_txv_rst", 32'(TX_VALID), 0);
        check_eq("mid_txd_rst", TX_DATA, 0);
        check_eq("mid_ints_rst", 32'({INT_TX, INT_RX}), 0);
        model_reset();
        apb.PSELx = 0; apb.PENABLE = 0;
        @(posedge PCLK);
        #1;
        PRESETn = 1;
        idle(0, 0, 0);
        apb_rd(16'h0018, rd, err);
        check_eq("post_rst_irq", rd, 0);
        apb_rd(16'h0010, rd, err);
        check_eq("post_rst_status", rd, 32'h0005_0000);

        random_phase(150);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
